adc_seq_fifo: RTL and testbench

- Parametrised successor to the single-channel ADC capture FIFO.
- Sequences conversions over a programmable channel mask, with optional inter-sample interval and a one-shot or continuous mode.
- Writes tagged samples into an internal synchronous FIFO; the host reads them through a 4-word Avalon-MM slave.
- Sits between the Avalon interconnect and an ADC serial core that exposes a go/done/channel/data handshake.

---
 rtl/adc_seq_fifo.sv | 195 +++++++++++++++++++
 tb/tb_adc_seq_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_fifo.sv
// Multi-channel ADC conversion sequencer with a tagged-sample FIFO behind a 4-word Avalon-MM slave.
// Cycles a channel mask, optionally pausing between conversions, in one-shot or continuous mode.
module adc_seq_fifo #(
    parameter  int DATA_W        = 12,
    parameter  int NUM_CH        = 8,
    parameter  int FIFO_DEPTH    = 256,
    parameter  int DISCARD_FIRST = 1,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              adc_go,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = CH_W + DATA_W;
    localparam logic [15:0] CH_VALID = (NUM_CH >= 16) ? 16'hFFFF : 16'((32'd1 << NUM_CH) - 32'd1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d, hist_q, hist_d;
    logic [15:0]     cnt_q, cnt_d, gap_q, gap_d;
    logic [15:0]     num_q, num_d, ival_q, ival_d, num_s_q, num_s_d, ival_s_q, ival_s_d;
    logic [15:0]     mask_q, mask_d, mask_s_q, mask_s_d;
    logic            disc_q, disc_d, cont_q, cont_d, irq_en_q, irq_en_d;
    logic            done_q, done_d, ovf_q, ovf_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [FW-1:0]   mem_q [FIFO_DEPTH];

    logic            full, empty, pop, push, push_ok, set_done, start, abort, busy;
    logic [FW-1:0]   push_ent;
    logic [31:0]     lvl32;
    logic [15:0]     lvl16;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [15:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[4'(i)]) lowest_ch = CH_W'(i);
    endfunction

    // Searches downward so the nearest set bit above cur wins; offset NUM_CH lands back on cur.
    function automatic logic [CH_W-1:0] next_ch(input logic [15:0] m, input logic [CH_W-1:0] cur);
        logic [3:0] j;
        next_ch = cur;
        for (int i = NUM_CH; i >= 1; i--) begin
            j = 4'((int'(cur) + i) % NUM_CH);
            if (m[j]) next_ch = CH_W'(j);
        end
    endfunction

    function automatic logic [31:0] data_word(input logic [FW-1:0] e);
        data_word = '0;
        data_word[31] = 1'b1;
        data_word[24 +: CH_W] = e[FW-1 -: CH_W];
        data_word[DATA_W-1:0] = e[DATA_W-1:0];
    endfunction

    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign pop      = read && (address == 2'd3) && !empty;
    assign push_ok  = push && (!full || pop);
    assign push_ent = {((DISCARD_FIRST != 0) ? hist_q : ptr_q), adc_data};
    assign lvl32    = 32'(level_q);
    assign lvl16    = (lvl32 > 32'h0000_FFFF) ? 16'hFFFF : lvl32[15:0];
    assign busy     = (state_q != S_IDLE);
    assign start    = write && (address == 2'd0) && writedata[0];
    assign abort    = write && (address == 2'd0) && writedata[1];

    always_comb begin
        state_d  = state_q;  ptr_d    = ptr_q;    hist_d   = hist_q;   cnt_d  = cnt_q;
        gap_d    = gap_q;    disc_d   = disc_q;   num_d    = num_q;    ival_d = ival_q;
        num_s_d  = num_s_q;  ival_s_d = ival_s_q; mask_d   = mask_q;   mask_s_d = mask_s_q;
        cont_d   = cont_q;   irq_en_d = irq_en_q; done_d   = done_q;   ovf_d  = ovf_q;
        rdata_d  = '0;
        push     = 1'b0;
        set_done = 1'b0;

        if (read) begin
            case (address)
                2'd0:    rdata_d = {mask_q, 12'd0, irq_en_q, cont_q, 2'b00};
                2'd1:    rdata_d = {ival_q, num_q};
                2'd2:    rdata_d = {lvl16, 13'd0, ovf_q, busy, done_q};
                default: rdata_d = empty ? 32'd0 : data_word(mem_q[rd_ptr_q]);
            endcase
            if (address == 2'd2) begin
                done_d = 1'b0;
                ovf_d  = 1'b0;
            end
        end
        if (write && address == 2'd0) begin
            cont_d   = writedata[2];
            irq_en_d = writedata[3];
            mask_d   = writedata[31:16] & CH_VALID;
        end
        if (write && address == 2'd1) begin
            num_d  = writedata[15:0];
            ival_d = writedata[31:16];
        end

        case (state_q)
            S_IDLE: if (start) begin
                if (((writedata[31:16] & CH_VALID) != '0) && (num_q != '0)) state_d = S_ARM;
                else set_done = 1'b1;
            end
            S_ARM: begin
                cnt_d    = '0;
                ptr_d    = lowest_ch(mask_q);
                disc_d   = (DISCARD_FIRST != 0);
                num_s_d  = num_q;
                ival_s_d = ival_q;
                mask_s_d = mask_q;
                state_d  = S_REQ;
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: if (adc_done) begin
                hist_d  = ptr_q;
                ptr_d   = next_ch(mask_s_q, ptr_q);
                gap_d   = '0;
                state_d = (ival_s_q != '0) ? S_GAP : S_REQ;
                if (disc_q) begin
                    disc_d = 1'b0;
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == num_s_q) begin
                        if (cont_q) begin
                            cnt_d = '0;
                        end else begin
                            state_d  = S_IDLE;
                            set_done = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == ival_s_q - 16'd1) state_d = S_REQ;
                else gap_d = gap_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything the FSM decided this cycle, including a coincident result.
        if (abort) begin
            state_d  = S_IDLE;
            push     = 1'b0;
            set_done = 1'b0;
        end
        if (set_done) done_d = 1'b1;
        if (push && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE; ptr_q    <= '0; hist_q   <= '0; cnt_q  <= '0;
            gap_q    <= '0;     disc_q   <= '0; num_q    <= '0; ival_q <= '0;
            num_s_q  <= '0;     ival_s_q <= '0; mask_q   <= '0; mask_s_q <= '0;
            cont_q   <= '0;     irq_en_q <= '0; done_q   <= '0; ovf_q  <= '0;
            rdata_q  <= '0;     wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0;
        end else begin
            state_q  <= state_d;  ptr_q    <= ptr_d;    hist_q   <= hist_d;   cnt_q  <= cnt_d;
            gap_q    <= gap_d;    disc_q   <= disc_d;   num_q    <= num_d;    ival_q <= ival_d;
            num_s_q  <= num_s_d;  ival_s_q <= ival_s_d; mask_q   <= mask_d;   mask_s_q <= mask_s_d;
            cont_q   <= cont_d;   irq_en_q <= irq_en_d; done_q   <= done_d;   ovf_q  <= ovf_d;
            rdata_q  <= rdata_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_ent;
    end

    assign readdata = rdata_q;
    assign adc_go   = (state_q == S_REQ);
    assign adc_ch   = ptr_q;
    assign irq      = irq_en_q & (done_q | ovf_q | (level_q >= LW'(FIFO_DEPTH / 2)));
endmodule

// File: tb/tb_adc_seq_fifo.sv
// Scoreboard bench: a transaction-level model predicts every Avalon read; a pipelined ADC responder
// returns the previous conversion's data and checks requested channels and request spacing.
module tb_adc_seq_fifo;
    localparam int DATA_W = 12;
    localparam int NUM_CH = 8;
    localparam int DEPTH  = 4;
    localparam int CH_W   = 3;
    localparam int LAT    = 4;
    localparam logic [15:0] VALID_MASK = 16'((1 << NUM_CH) - 1);

    logic              clock = 1'b0, reset = 1'b1;
    logic [1:0]        address = '0;
    logic              read = 1'b0, write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq, adc_go;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_done = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;

    always #5 clock = ~clock;

    adc_seq_fifo #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .DISCARD_FIRST(1)) dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq), .adc_go(adc_go),
        .adc_ch(adc_ch), .adc_done(adc_done), .adc_data(adc_data));

    int n_cmp = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0]       mq[$];
    logic [31:0]       exp_rd[$];
    logic [DATA_W-1:0] conv_data[$];
    bit                m_busy, m_done, m_ovf, m_cont, m_irq_en;
    logic [15:0]       m_mask, m_num, m_ival, m_run_mask, m_run_num, m_cnt;
    int                res_cnt = 0, go_idx = 0, timer = 0, cyc = 0, last_go = 0;
    bit                pend_stale, done_stale, spacing_on, chk_on;

    function automatic logic [CH_W-1:0] exp_ch(input logic [15:0] m, input int k);
        int bits[$];
        for (int i = 0; i < NUM_CH; i++) if (((m >> i) & 16'd1) != 0) bits.push_back(i);
        if (bits.size() == 0) return '0;
        return CH_W'(bits[k % bits.size()]);
    endfunction

    function automatic logic [31:0] status_word();
        return {16'(mq.size()), 13'd0, m_ovf, m_busy, m_done};
    endfunction

    always @(posedge clock) begin
        logic [31:0] e;
        cyc++;
        if (reset) begin
            mq.delete();
            {m_busy, m_done, m_ovf, m_cont, m_irq_en} = '0;
            {m_mask, m_num, m_ival, m_run_mask, m_run_num, m_cnt} = '0;
            pend_stale = 1'b1;
            res_cnt = 0;
        end else begin
            if (read) begin
                case (address)
                    2'd0:    e = {m_mask, 12'd0, m_irq_en, m_cont, 2'b00};
                    2'd1:    e = {m_ival, m_num};
                    2'd2:    e = status_word();
                    default: e = (mq.size() > 0) ? mq[0] : 32'd0;
                endcase
                exp_rd.push_back(e);
                if (address == 2'd2) begin m_done = 0; m_ovf = 0; end
                if (address == 2'd3 && mq.size() > 0) void'(mq.pop_front());
            end
            if (write && address == 2'd0) begin
                m_cont   = writedata[2];
                m_irq_en = writedata[3];
                m_mask   = writedata[31:16] & VALID_MASK;
                if (writedata[1]) begin
                    m_busy = 0;
                    pend_stale = 1'b1;
                end else if (writedata[0] && !m_busy) begin
                    if (m_mask != 0 && m_num != 0) begin
                        m_busy = 1; m_run_mask = m_mask; m_run_num = m_num; m_cnt = 0;
                        res_cnt = 0; go_idx = 0; conv_data.delete();
                    end else m_done = 1;
                end
            end
            if (write && address == 2'd1) {m_ival, m_num} = writedata;
            if (adc_done && !done_stale && m_busy) begin
                if (res_cnt > 0) begin
                    e = '0;
                    e[31] = 1'b1;
                    e[27:24] = 4'(exp_ch(m_run_mask, res_cnt - 1));
                    e[DATA_W-1:0] = conv_data[res_cnt - 1];
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else m_ovf = 1;
                    m_cnt++;
                    if (m_cnt == m_run_num) begin
                        if (m_cont) m_cnt = 0;
                        else begin m_busy = 0; m_done = 1; end
                    end
                end
                res_cnt++;
            end
        end
    end

    // Pipelined ADC: done arrives LAT cycles after go and carries the previous conversion.
    always @(negedge clock) begin
        adc_done = 1'b0;
        done_stale = 1'b0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                adc_done = 1'b1;
                done_stale = pend_stale;
                adc_data = (go_idx >= 2) ? conv_data[go_idx - 2] : DATA_W'($urandom);
            end
        end
        if (adc_go) begin
            chk("adc_ch", 32'(adc_ch), 32'(exp_ch(m_run_mask, go_idx)));
            if (spacing_on && go_idx > 0) chk("go_spacing", 32'(cyc - last_go), 32'(1 + 3 + 1 + 10));
            last_go = cyc;
            conv_data.push_back(DATA_W'($urandom));
            go_idx++;
            timer = LAT;
            pend_stale = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (exp_rd.size() > 0) chk("readdata", readdata, exp_rd.pop_front());
        if (chk_on && !reset)
            chk("irq", 32'(irq), 32'(m_irq_en & (m_done | m_ovf | (mq.size() >= DEPTH / 2))));
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock); address = a; writedata = d; write = 1'b1;
        @(negedge clock); write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clock); address = a; read = 1'b1;
        @(negedge clock); read = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 500 && m_busy; i++) @(negedge clock);
        if (m_busy) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: run still busy after 500 cycles", name);
        end
    endtask

    task automatic wait_go(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clock);
            if (adc_go) break;
        end
        if (i == 100) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no adc_go within 100 cycles", name);
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && mq.size() > 0; g++) rd(2'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_go", 32'(adc_go), 32'd0);
        chk("rst_ch", 32'(adc_ch), 32'd0);
        reset = 1'b0;
        chk_on = 1'b1;
        rd(2'd2);
        wr(2'd0, 32'hFF05_0000);
        rd(2'd0);

        // one-shot over channels 0 and 2
        wr(2'd1, 32'h0000_0004);
        wr(2'd0, 32'h0005_0009);
        wait_idle("oneshot");
        chk("go_count", 32'(go_idx), 32'd5);
        rd(2'd2);
        repeat (4) rd(2'd3);
        rd(2'd3);
        rd(2'd2);
        wr(2'd0, 32'h0000_0009);
        rd(2'd2);

        // inter-sample interval
        wr(2'd1, {16'd10, 16'd3});
        spacing_on = 1'b1;
        wr(2'd0, 32'h000A_0009);
        wait_idle("interval");
        spacing_on = 1'b0;
        rd(2'd2);
        drain();

        // overflow, then push and pop together while full
        wr(2'd1, 32'h0000_0006);
        wr(2'd0, 32'h0001_0009);
        wait_idle("overflow");
        rd(2'd2);
        rd(2'd2);
        wr(2'd1, 32'h0000_0001);
        wr(2'd0, 32'h0001_0009);
        wait_go("full_go1");
        wait_go("full_go2");
        repeat (LAT - 1) @(negedge clock);
        rd(2'd3);
        wait_idle("full_pushpop");
        rd(2'd2);
        drain();

        // continuous mode with a host reading every cycle, then abort mid-conversion
        wr(2'd1, 32'h0000_0002);
        wr(2'd0, 32'h0001_000D);
        @(negedge clock); address = 2'd3; read = 1'b1;
        repeat (60) @(negedge clock);
        read = 1'b0;
        wait_go("cont_go");
        wr(2'd0, 32'h0001_000E);
        rd(2'd2);
        repeat (8) @(negedge clock);
        rd(2'd2);
        drain();

        // reset during a conversion, then a fresh run
        wr(2'd1, 32'h0000_0003);
        wr(2'd0, 32'h0006_0009);
        wait_go("rst_go");
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        chk("wait_rst_readdata", readdata, 32'd0);
        chk("wait_rst_irq", 32'(irq), 32'd0);
        chk("wait_rst_go", 32'(adc_go), 32'd0);
        chk("wait_rst_ch", 32'(adc_ch), 32'd0);
        reset = 1'b0;
        rd(2'd2);
        rd(2'd3);
        wr(2'd1, 32'h0000_0002);
        wr(2'd0, 32'h0006_0009);
        wait_idle("after_reset");
        rd(2'd2);
        drain();
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
